reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Orders reset release for the FPGA top level, running on the undivided board clock.
- Merges external system reset with the debug module's ndmreset request.
- Drives the clock-divider reset, the debug-module reset and the SoC core reset in a fixed sequence, with programmable hold/settle times.
- Keeps the debug module out of reset during ndmreset, so JTAG stays connected across a debugger-initiated reset, and records the last reset cause.

Parameters:
SYNC_STAGES, 2, flops in the ndmreset_req synchronizer (>=2)
DIV_HOLD_CYCLES, 4, cycles div_rst is held after reset source removal (>=1)
SETTLE_CYCLES, 16, cycles after div_rst release before core/debug resets release (>=1)
NDM_RESETS_CLKDIV, 1, 1: ndmreset also cycles the clock divider; 0: divider untouched

Ports:
clk  input  1  board clock (free-running, undivided)
rst  input  1  synchronous active-high external reset, pre-synchronized to clk
ndmreset_req  input  1  debug-module ndmreset level, asynchronous (divided-clock domain)
div_rst  output  1  active-high reset to clock divider
dm_rst  output  1  active-high reset to debug module/transport
soc_rst  output  1  active-high reset to SoC core, bus and peripherals
ready  output  1  high only in RUN
reset_cause  output  2  sticky: 00 none, 01 external, 10 ndmreset

Behaviour:
- Synchronizer: ndmreset_req passes through SYNC_STAGES flops (reset to 0) giving ndm_s; latency SYNC_STAGES cycles.
- All outputs are dedicated flops loaded from next-state decode: output values equal the decode of the current state, with no combinational glitches.
- Internal ext_seq flag: set in RESET, cleared on entry to RUN.
- Counter width $clog2(max(DIV_HOLD_CYCLES,SETTLE_CYCLES)+1); cleared on every state change.
- States and outputs (div_rst/dm_rst/soc_rst/ready):
  - RESET: 1/1/1/0.
  - DIV_HOLD: 1/ext_seq/1/0.
  - SETTLE: 0/ext_seq/1/0.
  - RUN: 0/0/0/1.
  - NDM_ASSERT: NDM_RESETS_CLKDIV/ext_seq/1/0.
- Transitions (rst has priority over everything, from any state):
  - rst=1 -> RESET; reset_cause<=01; sync flops cleared.
  - RESET, rst=0 -> DIV_HOLD.
  - DIV_HOLD: ndm_s=1 -> NDM_ASSERT; else after DIV_HOLD_CYCLES cycles -> SETTLE.
  - SETTLE: ndm_s=1 -> NDM_ASSERT; else after SETTLE_CYCLES cycles -> RUN.
  - RUN: ndm_s=1 -> NDM_ASSERT; reset_cause<=10.
  - NDM_ASSERT: stay while ndm_s=1. On ndm_s=0 -> DIV_HOLD if NDM_RESETS_CLKDIV=1, else SETTLE.
- Release timing:
  - From first clk edge sampling rst=0: div_rst falls after DIV_HOLD_CYCLES cycles; dm_rst/soc_rst/ready change after DIV_HOLD_CYCLES+SETTLE_CYCLES cycles (defaults 4 and 20).
  - From first edge where ndm_s=0: the same timing applies when NDM_RESETS_CLKDIV=1; with NDM_RESETS_CLKDIV=0, soc_rst falls after SETTLE_CYCLES.
- Boundary conditions:
  - ndmreset during an external boot sequence: restarts from NDM_ASSERT; dm_rst stays asserted (ext_seq=1); reset_cause stays 01.
  - ndmreset pulse shorter than one clk period may be missed. The debug module holds ndmreset for at least 2 divided-clock cycles, so this does not occur in the system.
  - rst asserted mid-sequence: next cycle all outputs are 1 and the counter is cleared.
- Power-up: the FPGA initialises the state register to RESET, with reset_cause=00 until the first rst.

Test Plan:
1. Hold rst=1 for 5 cycles, then release at edge E0 -> all resets 1 while rst high; div_rst=0 at E0+4; dm_rst=soc_rst=0 and ready=1 at E0+20; reset_cause=01.
2. In RUN, raise ndmreset_req for 10 cycles -> soc_rst=1 and div_rst=1 SYNC_STAGES(2)+1 cycles later; dm_rst stays 0 throughout; reset_cause=10; soc_rst=0 again 20 cycles after ndm_s falls.
3. NDM_RESETS_CLKDIV=0, repeat scenario 2 -> div_rst never asserts; soc_rst=0 16 cycles after ndm_s falls.
4. Raise ndmreset_req at E0+10 during an external boot -> state NDM_ASSERT; dm_rst remains 1 until the final release; reset_cause remains 01.
5. Assert rst for 1 cycle while in NDM_ASSERT -> all outputs 1 next cycle; reset_cause=01; full 4/20 sequence follows, with dm_rst asserted.
6. Run DIV_HOLD_CYCLES=1, SETTLE_CYCLES=1 -> div_rst falls 1 cycle, soc_rst 2 cycles after rst release; no counter wrap or stall.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: orders reset release at the FPGA top level.
// Merges the external reset with the debugger's ndmreset request. It then
// releases the clock divider, the debug module and the SoC core in a fixed
// order, with programmable hold and settle times.
// The debug module stays out of reset across an ndmreset from RUN, so the
// JTAG session survives a debugger-initiated reset.
// The last reset cause is held in a sticky register.
//
// Handshake note: this block has no valid/ready handshakes. All inputs are
// levels, and every output is a plain registered level.
module reset_sequencer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DIV_HOLD_CYCLES   = 4,
  parameter int SETTLE_CYCLES     = 16,
  parameter int NDM_RESETS_CLKDIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ndmreset_req,
  output logic       div_rst,
  output logic       dm_rst,
  output logic       soc_rst,
  output logic       ready,
  output logic [1:0] reset_cause
);

  localparam int MAX_CYC = (DIV_HOLD_CYCLES > SETTLE_CYCLES) ? DIV_HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(DIV_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic             NDM_DIV     = (NDM_RESETS_CLKDIV != 0);

  // RESET is encoded as all-zero, so a zero-initialised state register powers up in RESET.
  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_DIV_HOLD   = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_NDM_ASSERT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ext_seq_q, ext_seq_d;
  logic [1:0]         cause_q, cause_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               ndm_s;
  logic               div_d, dm_d, soc_d, ready_d;

  // ndmreset_req crosses from the divided-clock domain through a plain flop chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ndmreset_req};
  end

  assign ndm_s = sync_q[SYNC_STAGES-1];

  // Next-state, counter, sequence-flag and cause decode; rst overrides everything.
  always_comb begin
    state_d   = state_q;
    ext_seq_d = ext_seq_q;
    cause_d   = cause_q;
    if (rst) begin
      state_d   = ST_RESET;
      ext_seq_d = 1'b1;
      cause_d   = 2'b01;
    end else begin
      case (state_q)
        ST_RESET: begin
          ext_seq_d = 1'b1;
          state_d   = ST_DIV_HOLD;
        end
        ST_DIV_HOLD: begin
          if (ndm_s)                   state_d = ST_NDM_ASSERT;
          else if (cnt_q == HOLD_LAST) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (ndm_s) begin
            state_d = ST_NDM_ASSERT;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d   = ST_RUN;
            ext_seq_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (ndm_s) begin
            state_d = ST_NDM_ASSERT;
            cause_d = 2'b10;
          end
        end
        ST_NDM_ASSERT: begin
          if (!ndm_s) state_d = NDM_DIV ? ST_DIV_HOLD : ST_SETTLE;
        end
        default: state_d = ST_RESET;
      endcase
    end

    // The counter only runs in the timed states and restarts on every state change.
    cnt_d = '0;
    if (!rst && (state_d == state_q) &&
        ((state_q == ST_DIV_HOLD) || (state_q == ST_SETTLE)))
      cnt_d = cnt_q + CNT_ONE;
  end

  // Output decode of the next state, so the output flops match the state they enter.
  always_comb begin
    div_d   = 1'b1;
    dm_d    = 1'b1;
    soc_d   = 1'b1;
    ready_d = 1'b0;
    case (state_d)
      ST_RESET:      begin div_d = 1'b1;    dm_d = 1'b1;      soc_d = 1'b1; ready_d = 1'b0; end
      ST_DIV_HOLD:   begin div_d = 1'b1;    dm_d = ext_seq_d; soc_d = 1'b1; ready_d = 1'b0; end
      ST_SETTLE:     begin div_d = 1'b0;    dm_d = ext_seq_d; soc_d = 1'b1; ready_d = 1'b0; end
      ST_RUN:        begin div_d = 1'b0;    dm_d = 1'b0;      soc_d = 1'b0; ready_d = 1'b1; end
      ST_NDM_ASSERT: begin div_d = NDM_DIV; dm_d = ext_seq_d; soc_d = 1'b1; ready_d = 1'b0; end
      default:       begin div_d = 1'b1;    dm_d = 1'b1;      soc_d = 1'b1; ready_d = 1'b0; end
    endcase
  end

  // Sequencer state and glitch-free registered outputs.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    ext_seq_q   <= ext_seq_d;
    cause_q     <= cause_d;
    div_rst     <= div_d;
    dm_rst      <= dm_d;
    soc_rst     <= soc_d;
    ready       <= ready_d;
  end

  assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of reset_sequencer release ordering.
// dut_a uses the default parameters, dut_b has NDM_RESETS_CLKDIV=0, and
// dut_c uses DIV_HOLD_CYCLES=SETTLE_CYCLES=1. rst is shared by all three.
// Inputs are driven on the falling edge and outputs are sampled there too.
// Output vectors are packed as {div_rst, dm_rst, soc_rst, ready}.
module tb_reset_sequencer;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ndm_a = 1'b0, ndm_b = 1'b0, ndm_c = 1'b0;
  logic div_a, dm_a, soc_a, rdy_a;
  logic div_b, dm_b, soc_b, rdy_b;
  logic div_c, dm_c, soc_c, rdy_c;
  logic [1:0] cause_a, cause_b, cause_c;
  logic [3:0] out_a, out_b, out_c;

  assign out_a = {div_a, dm_a, soc_a, rdy_a};
  assign out_b = {div_b, dm_b, soc_b, rdy_b};
  assign out_c = {div_c, dm_c, soc_c, rdy_c};

  reset_sequencer dut_a (
    .clk(clk), .rst(rst), .ndmreset_req(ndm_a),
    .div_rst(div_a), .dm_rst(dm_a), .soc_rst(soc_a), .ready(rdy_a),
    .reset_cause(cause_a)
  );

  reset_sequencer #(.NDM_RESETS_CLKDIV(0)) dut_b (
    .clk(clk), .rst(rst), .ndmreset_req(ndm_b),
    .div_rst(div_b), .dm_rst(dm_b), .soc_rst(soc_b), .ready(rdy_b),
    .reset_cause(cause_b)
  );

  reset_sequencer #(.DIV_HOLD_CYCLES(1), .SETTLE_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .ndmreset_req(ndm_c),
    .div_rst(div_c), .dm_rst(dm_c), .soc_rst(soc_c), .ready(rdy_c),
    .reset_cause(cause_c)
  );

  // Scoreboard counters.
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver helper: advance n falling edges.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1 + 6: external boot. E0 is the first rising edge that samples rst=0.
    cyc(5);
    check_eq("t1_hold_a", out_a, 4'b1110);
    check_eq("t1_hold_c", out_c, 4'b1110);
    check_eq("t1_cause_a", cause_a, 2'b01);
    rst = 1'b0;
    cyc(1);                                    // E0
    check_eq("t1_e0_a", out_a, 4'b1110);
    check_eq("t6_e0_c", out_c, 4'b1110);
    cyc(1);                                    // E0+1
    check_eq("t6_e1_c", out_c, 4'b0110);
    cyc(1);                                    // E0+2
    check_eq("t6_e2_c", out_c, 4'b0001);
    cyc(1);                                    // E0+3
    check_eq("t1_e3_a", out_a, 4'b1110);
    cyc(1);                                    // E0+4
    check_eq("t1_e4_a", out_a, 4'b0110);
    cyc(15);                                   // E0+19
    check_eq("t1_e19_a", out_a, 4'b0110);
    cyc(1);                                    // E0+20
    check_eq("t1_e20_a", out_a, 4'b0001);
    check_eq("t1_e20_b", out_b, 4'b0001);
    check_eq("t1_cause_run", cause_a, 2'b01);

    // 2: ndmreset from RUN with the divider cycled; dm_rst stays low.
    ndm_a = 1'b1;
    cyc(2);
    check_eq("t2_sync_a", out_a, 4'b0001);
    cyc(1);
    check_eq("t2_ndm_a", out_a, 4'b1010);
    check_eq("t2_cause_a", cause_a, 2'b10);
    cyc(7);
    check_eq("t2_hold_a", out_a, 4'b1010);
    ndm_a = 1'b0;
    cyc(3);                                    // first edge seeing ndm_s=0
    check_eq("t2_q0_a", out_a, 4'b1010);
    cyc(4);
    check_eq("t2_q4_a", out_a, 4'b0010);
    cyc(15);
    check_eq("t2_q19_a", out_a, 4'b0010);
    cyc(1);
    check_eq("t2_q20_a", out_a, 4'b0001);
    check_eq("t2_cause_end", cause_a, 2'b10);

    // 3: ndmreset without cycling the divider.
    ndm_b = 1'b1;
    cyc(2);
    check_eq("t3_sync_b", out_b, 4'b0001);
    cyc(1);
    check_eq("t3_ndm_b", out_b, 4'b0010);
    check_eq("t3_cause_b", cause_b, 2'b10);
    cyc(7);
    ndm_b = 1'b0;
    cyc(3);
    check_eq("t3_q0_b", out_b, 4'b0010);
    cyc(15);
    check_eq("t3_q15_b", out_b, 4'b0010);
    cyc(1);
    check_eq("t3_q16_b", out_b, 4'b0001);

    // 4: ndmreset arriving during an external boot keeps dm_rst and cause 01.
    rst = 1'b1;
    cyc(3);
    check_eq("t4_rst_a", out_a, 4'b1110);
    check_eq("t4_cause_rst", cause_a, 2'b01);
    rst = 1'b0;
    cyc(10);                                   // E0+9
    check_eq("t4_e9_a", out_a, 4'b0110);
    ndm_a = 1'b1;
    cyc(2);                                    // E0+11
    check_eq("t4_e11_a", out_a, 4'b0110);
    cyc(1);                                    // E0+12: NDM_ASSERT
    check_eq("t4_ndm_a", out_a, 4'b1110);
    check_eq("t4_cause_ndm", cause_a, 2'b01);
    cyc(5);
    ndm_a = 1'b0;
    cyc(3);
    check_eq("t4_q0_a", out_a, 4'b1110);
    cyc(4);
    check_eq("t4_q4_a", out_a, 4'b0110);
    cyc(15);
    check_eq("t4_q19_a", out_a, 4'b0110);
    cyc(1);
    check_eq("t4_q20_a", out_a, 4'b0001);
    check_eq("t4_cause_end", cause_a, 2'b01);

    // 5: one-cycle rst while in NDM_ASSERT restarts the full sequence.
    ndm_a = 1'b1;
    cyc(3);
    check_eq("t5_ndm_a", out_a, 4'b1010);
    check_eq("t5_cause_ndm", cause_a, 2'b10);
    rst   = 1'b1;
    ndm_a = 1'b0;
    cyc(1);
    check_eq("t5_rst_a", out_a, 4'b1110);
    check_eq("t5_cause_rst", cause_a, 2'b01);
    rst = 1'b0;
    cyc(1);                                    // E0
    check_eq("t5_e0_a", out_a, 4'b1110);
    cyc(1);                                    // E0+1
    check_eq("t5_e1_c", out_c, 4'b0110);
    cyc(1);                                    // E0+2
    check_eq("t5_e2_c", out_c, 4'b0001);
    cyc(2);                                    // E0+4
    check_eq("t5_e4_a", out_a, 4'b0110);
    cyc(15);                                   // E0+19
    check_eq("t5_e19_a", out_a, 4'b0110);
    cyc(1);                                    // E0+20
    check_eq("t5_e20_a", out_a, 4'b0001);

    // Final report.
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
